// File: rtl/bnn_dot_initiator.sv
// bnn_dot_initiator: streams (a, b) word pairs through a combinational CFU-L0 BNN
// responder, accumulates popcounts and returns the signed dot product 2*popsum - len*W.
`default_nettype none

package bnn_dot_cfu_pkg;
    typedef enum logic [1:0] {
        CFU_OK      = 2'd0,
        CFU_ERROR   = 2'd1,
        CFU_TIMEOUT = 2'd2,
        CFU_INVALID = 2'd3
    } cfu_status_t;
endpackage

module bnn_dot_initiator
    import bnn_dot_cfu_pkg::*;
#(
    parameter int CFU_DATA_W    = 32,
    parameter int CFU_CFU_ID_W  = 0,
    parameter int CFU_FUNC_ID_W = 0,
    parameter int MAX_WORDS     = 256,
    parameter int ACC_W         = 32,
    localparam int LEN_W        = $clog2(MAX_WORDS + 1),
    localparam int CFU_ID_PW    = (CFU_CFU_ID_W > 0) ? CFU_CFU_ID_W : 1,
    localparam int FUNC_ID_PW   = (CFU_FUNC_ID_W > 0) ? CFU_FUNC_ID_W : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [LEN_W-1:0]        cmd_len,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [CFU_DATA_W-1:0]   in_a,
    input  logic [CFU_DATA_W-1:0]   in_b,
    output logic                    req_valid,
    output logic [CFU_ID_PW-1:0]    req_cfu,
    output logic [FUNC_ID_PW-1:0]   req_func,
    output logic [CFU_DATA_W-1:0]   req_data0,
    output logic [CFU_DATA_W-1:0]   req_data1,
    input  cfu_status_t             resp_status,
    input  logic [CFU_DATA_W-1:0]   resp_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [ACC_W-1:0] out_dot,
    output logic                    out_err
);

    localparam int PS_W = LEN_W + $clog2(CFU_DATA_W);
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_WORDS);
    localparam logic [LEN_W-1:0] ONE_LEN = LEN_W'(1);
    localparam logic [ACC_W-1:0] DW_ACC  = ACC_W'(CFU_DATA_W);

    if (!(CFU_DATA_W == 32 || CFU_DATA_W == 64)) begin : g_bad_data_w
        $error("bnn_dot_initiator: CFU_DATA_W must be 32 or 64");
    end
    if (ACC_W < $clog2(MAX_WORDS * CFU_DATA_W + 1) + 1) begin : g_bad_acc_w
        $error("bnn_dot_initiator: ACC_W too narrow for MAX_WORDS*CFU_DATA_W");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                    state_q;
    logic [LEN_W-1:0]          remaining_q;
    logic [LEN_W-1:0]          len_q;
    logic [PS_W-1:0]           popsum_q;
    logic                      err_q;
    logic                      cmd_ready_q;
    logic                      in_ready_q;
    logic                      out_valid_q;
    logic                      out_err_q;
    logic signed [ACC_W-1:0]   out_dot_q;

    logic [LEN_W-1:0]          len_clamped;
    logic [PS_W-1:0]           popsum_d;
    logic                      err_d;
    logic signed [ACC_W-1:0]   dot_d;
    logic                      beat;
    logic                      w_unused;

    assign len_clamped = (cmd_len > MAX_LEN) ? MAX_LEN : cmd_len;
    assign beat        = in_valid & in_ready_q;

    // Next popsum/err include the beat in flight, so the final dot is ready on the last beat.
    always_comb begin
        popsum_d = popsum_q + resp_data[PS_W-1:0];
        err_d    = err_q | (resp_status != CFU_OK);
        dot_d    = $signed(ACC_W'({popsum_d, 1'b0}) - ACC_W'(len_q) * DW_ACC);
    end

    assign w_unused = ^resp_data[CFU_DATA_W-1:PS_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            len_q       <= '0;
            popsum_q    <= '0;
            err_q       <= 1'b0;
            cmd_ready_q <= 1'b1;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_err_q   <= 1'b0;
            out_dot_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        remaining_q <= len_clamped;
                        len_q       <= len_clamped;
                        popsum_q    <= '0;
                        err_q       <= 1'b0;
                        cmd_ready_q <= 1'b0;
                        if (len_clamped == '0) begin
                            state_q     <= ST_DONE;
                            out_valid_q <= 1'b1;
                            out_dot_q   <= '0;
                            out_err_q   <= 1'b0;
                        end else begin
                            state_q    <= ST_RUN;
                            in_ready_q <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (beat) begin
                        popsum_q    <= popsum_d;
                        err_q       <= err_d;
                        remaining_q <= remaining_q - ONE_LEN;
                        if (remaining_q == ONE_LEN) begin
                            state_q     <= ST_DONE;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                            out_dot_q   <= dot_d;
                            out_err_q   <= err_d;
                        end
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_q     <= ST_IDLE;
                        out_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    cmd_ready_q <= 1'b1;
                    in_ready_q  <= 1'b0;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_dot   = out_dot_q;
    assign out_err   = out_err_q;

    // Responder inputs are held at zero outside RUN so it sees no toggling.
    assign req_valid = beat;
    assign req_data0 = in_ready_q ? in_a : '0;
    assign req_data1 = in_ready_q ? in_b : '0;
    assign req_cfu   = '0;
    assign req_func  = '0;

endmodule

`default_nettype wire

// File: tb/tb_bnn_dot_initiator.sv
// Randomized self-checking bench for bnn_dot_initiator against a popcount/XNOR reference model.
`default_nettype none

module tb_bnn_dot_initiator;
    import bnn_dot_cfu_pkg::*;

    localparam int DW    = 32;
    localparam int MAXW  = 256;
    localparam int ACCW  = 32;
    localparam int LEN_W = $clog2(MAXW + 1);

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cmd_valid, cmd_ready;
    logic [LEN_W-1:0]  cmd_len;
    logic              in_valid, in_ready;
    logic [DW-1:0]     in_a, in_b;
    logic              req_valid;
    logic [0:0]        req_cfu, req_func;
    logic [DW-1:0]     req_data0, req_data1;
    cfu_status_t       resp_status;
    logic [DW-1:0]     resp_data;
    logic              out_valid, out_ready;
    logic signed [ACCW-1:0] out_dot;
    logic              out_err;

    int n_checks = 0;
    int n_errors = 0;
    int rv_cnt   = 0;

    logic [DW-1:0] qa[$];
    logic [DW-1:0] qb[$];
    cfu_status_t   qs[$];

    always #5 clk = ~clk;

    bnn_dot_initiator #(
        .CFU_DATA_W(DW), .CFU_CFU_ID_W(0), .CFU_FUNC_ID_W(0),
        .MAX_WORDS(MAXW), .ACC_W(ACCW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .req_valid(req_valid), .req_cfu(req_cfu), .req_func(req_func),
        .req_data0(req_data0), .req_data1(req_data1),
        .resp_status(resp_status), .resp_data(resp_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_dot(out_dot), .out_err(out_err)
    );

    // Combinational BNN responder: XNOR popcount of the request operands.
    always_comb resp_data = DW'($countones(~(req_data0 ^ req_data1)));

    always @(posedge clk) if (req_valid) rv_cnt <= rv_cnt + 1;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Run one command over the pairs in qa/qb/qs. gap: 0 none, 1 alternate, 2 random.
    task automatic run_cmd(input int cmd, input int gap, input int hold);
        int n;
        longint pop;
        bit err;
        int rv_base;
        longint dot_exp;
        logic signed [ACCW-1:0] dot_seen;
        n   = (cmd > MAXW) ? MAXW : cmd;
        pop = 0;
        err = 1'b0;
        check("cmd_ready_idle", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_len   = LEN_W'(cmd);
        rv_base   = rv_cnt;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        check("cmd_ready_busy", cmd_ready, 0);
        for (int i = 0; i < n; i++) begin
            if (gap == 1 || (gap == 2 && $urandom_range(3) == 0)) begin
                in_valid = 1'b0;
                in_a     = $urandom;
                @(posedge clk); #1;
            end
            in_valid    = 1'b1;
            in_a        = qa[i];
            in_b        = qb[i];
            resp_status = qs[i];
            pop += $countones(~(qa[i] ^ qb[i]));
            err |= (qs[i] != CFU_OK);
            if (i < 4 || i == n - 1) check("in_ready_run", in_ready, 1);
            @(posedge clk); #1;
        end
        in_valid    = 1'b0;
        resp_status = CFU_OK;
        dot_exp = 2 * pop - longint'(n) * DW;
        check("out_valid_latency", out_valid, 1);
        check("out_dot", out_dot, dot_exp);
        check("out_err", out_err, err);
        check("in_ready_done", in_ready, 0);
        dot_seen = out_dot;
        for (int k = 0; k < hold; k++) begin
            cmd_valid = 1'b1;
            @(posedge clk); #1;
            check("hold_out_valid", out_valid, 1);
            check("hold_out_dot", out_dot, dot_seen);
            check("hold_cmd_ready", cmd_ready, 0);
        end
        cmd_valid = 1'b0;
        check("req_pulses", rv_cnt - rv_base, n);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("out_valid_cleared", out_valid, 0);
        check("cmd_ready_back", cmd_ready, 1);
    endtask

    task automatic fill(input int n, input int mode);
        qa.delete(); qb.delete(); qs.delete();
        for (int i = 0; i < n; i++) begin
            qa.push_back($urandom);
            qb.push_back($urandom);
            if (mode == 1 && $urandom_range(5) == 0)
                qs.push_back(cfu_status_t'($urandom_range(3, 1)));
            else
                qs.push_back(CFU_OK);
        end
    endtask

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_len = '0; in_valid = 1'b0;
        in_a = 32'hDEADBEEF; in_b = 32'h12345678; out_ready = 1'b0;
        resp_status = CFU_OK;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_dot", out_dot, 0);
        check("rst_out_err", out_err, 0);
        check("rst_req_data0", req_data0, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b1;
        #1;
        check("idle_req_valid", req_valid, 0);
        in_valid = 1'b0;

        qa = '{32'hFFFF_FFFF}; qb = '{32'hFFFF_FFFF}; qs = '{CFU_OK};
        run_cmd(1, 0, 0);
        qa = '{32'h0000_0000}; qb = '{32'hFFFF_FFFF}; qs = '{CFU_OK};
        run_cmd(1, 0, 0);
        qa = '{4{32'h0000_FFFF}}; qb = '{4{32'h0}}; qs = '{4{CFU_OK}};
        run_cmd(4, 1, 0);
        run_cmd(0, 0, 0);
        qa = '{32'hFFFF_FFFF, 32'h0000_0000, 32'hA5A5_A5A5};
        qb = '{32'hFFFF_FFFF, 32'hFFFF_FFE0, 32'hA5A5_A5A5};
        qs = '{CFU_OK, CFU_ERROR, CFU_OK};
        run_cmd(3, 0, 5);

        for (int t = 0; t < 20; t++) begin
            int len;
            len = $urandom_range(12);
            fill(len, 1);
            run_cmd(len, 2, $urandom_range(2));
        end
        fill(MAXW, 0);
        run_cmd(300, 0, 0);
        fill(MAXW, 1);
        run_cmd(MAXW, 0, 0);

        fill(5, 0);
        cmd_valid = 1'b1; cmd_len = LEN_W'(5);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        in_valid = 1'b1; in_a = qa[0]; in_b = qb[0];
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrun_out_valid", out_valid, 0);
        check("midrun_cmd_ready", cmd_ready, 1);
        check("midrun_in_ready", in_ready, 0);
        check("midrun_req_valid", req_valid, 0);
        @(negedge clk) rst_n = 1'b1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        fill(6, 1);
        run_cmd(6, 2, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
